// File: rtl/alu_issue.sv
// alu_issue: RV32I integer decode-and-issue stage feeding the ALU.
// It decodes one instruction word into an ALU op code and two operands.
// The output is a registered valid/ready port backed by one skid entry,
// so the upstream ready signal comes straight from a flop.
// Saturating counters record how many legal and illegal entries the ALU took.
module alu_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_rs1_val,
  input  logic [31:0]      in_rs2_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_op,
  output logic [31:0]      out_r1,
  output logic [31:0]      out_r2,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] cnt_issued,
  output logic [CNT_W-1:0] cnt_illegal
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_OR   = 4'b1000;
  localparam logic [3:0] OP_AND  = 4'b1001;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rd;
    logic        ill;
  } entry_t;

  entry_t dec, out_q, out_d, skid_q, skid_d;
  logic   out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic   acc_in, acc_out;
  logic [CNT_W-1:0] cnt_iss_q, cnt_ill_q;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_u;

  assign opc   = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u = {in_instr[31:12], 12'b0};

  assign acc_in  = in_valid && in_ready;
  assign acc_out = out_valid && out_ready;

  // Decode the incoming word; illegal encodings collapse to an all-zero payload.
  always_comb begin
    dec     = '0;
    dec.ill = 1'b1;
    case (opc)
      7'b0110011: begin
        dec.r1 = in_rs1_val;
        dec.r2 = in_rs2_val;
        if (f7 == 7'b0000000) begin
          dec.ill = 1'b0;
          case (f3)
            3'b000:  dec.op = OP_ADD;
            3'b001:  dec.op = OP_SLL;
            3'b010:  dec.op = OP_SLT;
            3'b011:  dec.op = OP_SLTU;
            3'b100:  dec.op = OP_XOR;
            3'b101:  dec.op = OP_SRL;
            3'b110:  dec.op = OP_OR;
            default: dec.op = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec.ill = 1'b0;
          dec.op  = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec.ill = 1'b0;
          dec.op  = OP_SRA;
        end
        // The ALU shifts by the whole r2, so only the low five bits may survive.
        if (f3 == 3'b001 || f3 == 3'b101) dec.r2 = {27'b0, in_rs2_val[4:0]};
      end
      7'b0010011: begin
        dec.r1  = in_rs1_val;
        dec.r2  = imm_i;
        dec.ill = 1'b0;
        case (f3)
          3'b000: dec.op = OP_ADD;
          3'b010: dec.op = OP_SLT;
          3'b011: dec.op = OP_SLTU;
          3'b100: dec.op = OP_XOR;
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
          3'b001: begin
            dec.op  = OP_SLL;
            dec.r2  = {27'b0, in_instr[24:20]};
            dec.ill = (f7 != 7'b0000000);
          end
          default: begin
            dec.op  = (f7 == 7'b0100000) ? OP_SRA : OP_SRL;
            dec.r2  = {27'b0, in_instr[24:20]};
            dec.ill = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          end
        endcase
      end
      7'b0110111: begin
        dec.ill = 1'b0;
        dec.r2  = imm_u;
      end
      7'b0010111: begin
        dec.ill = 1'b0;
        dec.r1  = in_pc;
        dec.r2  = imm_u;
      end
      default: dec.ill = 1'b1;
    endcase
    if (dec.ill) begin
      dec     = '0;
      dec.ill = 1'b1;
    end else begin
      dec.rd = in_instr[11:7];
    end
  end

  // Next-state for the output register and skid entry; order is always output first.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      if (acc_out) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (!out_vld_q || acc_out) begin
      out_vld_d = acc_in;
      if (acc_in) out_d = dec;
    end else if (acc_in) begin
      skid_d     = dec;
      skid_vld_d = 1'b1;
    end
  end

  // Pipeline state; a reset drops both entries and clears the visible outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Saturating debug counters, stepped on each downstream handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_iss_q <= '0;
      cnt_ill_q <= '0;
    end else if (acc_out) begin
      if (!out_q.ill && cnt_iss_q != '1) cnt_iss_q <= cnt_iss_q + CNT_W'(1);
      if (out_q.ill && cnt_ill_q != '1)  cnt_ill_q <= cnt_ill_q + CNT_W'(1);
    end
  end

  assign in_ready    = !skid_vld_q;
  assign out_valid   = out_vld_q;
  assign out_op      = out_q.op;
  assign out_r1      = out_q.r1;
  assign out_r2      = out_q.r2;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.ill;
  assign cnt_issued  = cnt_iss_q;
  assign cnt_illegal = cnt_ill_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage on the producer side of the ALU op interface. Accepts RV32I integer instruction words with their source-register values and program counter, decodes them into the 4-bit ALU op code plus two 32-bit operands, and presents them to the ALU through a registered valid/ready output with a 2-entry skid buffer. Flags non-ALU or malformed encodings as illegal and keeps saturating issue/illegal counters for debug.

## Interface
- CNT_W, 16, width of the issue and illegal counters

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept (registered)
- in_instr  in  32  instruction word
- in_pc  in  32  instruction address (AUIPC operand)
- in_rs1_val  in  32  value of register rs1
- in_rs2_val  in  32  value of register rs2
- out_valid  out  1  issued op valid
- out_ready  in  1  ALU/writeback side accepts
- out_op  out  4  ALU op code
- out_r1  out  32  ALU operand 1
- out_r2  out  32  ALU operand 2
- out_rd  out  5  destination register
- out_illegal  out  1  entry carries an illegal encoding
- cnt_issued  out  CNT_W  legal entries accepted downstream, saturating
- cnt_illegal  out  CNT_W  illegal entries accepted downstream, saturating

## Operation
- Op codes: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
- The ALU shifts by the full r2; for all shifts this stage drives out_r2 = {27'b0, shamt[4:0]}.
- opcode 0110011 (R-type): funct7 0000000 with funct3 000..111 -> ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND; funct7 0100000 with funct3 000 -> SUB, 101 -> SRA. r1 = rs1_val, r2 = rs2_val (or masked shamt for shifts). Any other funct7/funct3 pair is illegal.
- opcode 0010011 (I-type): imm = sign-extended instr[31:20]. funct3 000 ADD, 010 SLT, 011 SLTU, 100 XOR, 110 OR, 111 AND with r2 = imm. funct3 001 SLL requires instr[31:25] = 0; 101 requires instr[31:25] = 0000000 (SRL) or 0100000 (SRA); otherwise illegal. r1 = rs1_val.
- opcode 0110111 (LUI): ADD, r1 = 0, r2 = {instr[31:12], 12'b0}.
- opcode 0010111 (AUIPC): ADD, r1 = in_pc, r2 = {instr[31:12], 12'b0}.
- out_rd = instr[11:7] for legal entries.
- Any other opcode is illegal. Illegal entries still flow through in order with out_illegal = 1, op 0000, r1 = r2 = 0, rd = 0.
- Counters increment on out_valid && out_ready, selected by out_illegal, and hold at all-ones.

## Timing
- Reset: out_valid 0, skid empty, in_ready 1, out_op/out_r1/out_r2/out_rd/out_illegal 0, both counters 0. Async assert, synchronous-effect release on the next clk edge.
- Input accept when in_valid && in_ready; decoded entry appears on outputs the next cycle (latency 1).
- Output register holds while out_valid && !out_ready; outputs stay stable until accepted.
- Skid buffer: an accept while the output is stalled goes to the skid entry. in_ready = !skid_valid, driven from a flop, and drops the cycle after the skid fills.
- Output accepted with the skid full: the skid moves to the output next cycle and in_ready returns to 1. A simultaneous new accept is impossible because in_ready is 0.
- Output accepted with the skid empty and a new input accepted in the same cycle: the new entry loads directly into the output register, with no bubble. Sustained throughput is 1 per cycle.
- Order is strictly preserved, including illegal entries.
- Reset mid-stream discards both entries; no partial entry is emitted.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1 = 5, rs2 = 7, out_ready = 1 -> next cycle out_op 0000, r1 5, r2 7, rd 3, illegal 0; cnt_issued 1.
- SUB (0x402081B3), then SRAI x5,x6,3 (0x40335293) with rs1 = 0x80000000 -> op 0001, then op 0111 with r2 = 3 and rd 5. For SLL with rs2 = 0x00000123, r2 = 0x00000003.
- ADDI x1,x0,-1 (0xFFF00093) -> op 0000, r2 0xFFFFFFFF. LUI x7,0x12345 (0x123453B7) -> r1 0, r2 0x12345000, rd 7. AUIPC with pc 0x100 -> r1 0x100.
- MUL encoding 0x022081B3 and load opcode 0x00002083 -> out_illegal 1, op 0, rd 0, cnt_illegal 2, cnt_issued unchanged.
- Back-to-back 4 instructions, out_ready low 3 cycles -> skid fills, in_ready 0 the following cycle. Release out_ready -> all 4 emerge in order with no drop or duplicate.
- Assert rst_n low while output and skid are both full -> out_valid 0 immediately, in_ready 1, counters 0. Force CNT_W = 2 with 5 issues -> cnt_issued saturates at 3.
